// File: rtl/adc_moving_avg.sv
// Boxcar moving average over the last 2^LOG2N ADC samples. The output is registered two edges
// after the accepted strobe, and an optional bypass passes the raw sample with the same latency.
module adc_moving_avg #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned LOG2N  = 3
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              bypass,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned SumW = DATA_W + LOG2N;

  typedef enum logic [1:0] {StIdle, StUpdate, StOut} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_buf [N];
  logic [LOG2N-1:0]  r_wr_ptr;
  logic [SumW-1:0]   r_sum;
  logic [DATA_W-1:0] r_new_s;
  logic [DATA_W-1:0] r_old_s;
  logic              r_byp;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_out_valid;
  logic              r_overrun;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (data_valid) w_state_next = StUpdate;
      StUpdate: w_state_next = StOut;
      StOut:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state          <= StIdle;
      r_wr_ptr         <= '0;
      r_sum            <= '0;
      r_new_s          <= '0;
      r_old_s          <= '0;
      r_byp            <= 1'b0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_overrun        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_state          <= w_state_next;
      r_data_out_valid <= 1'b0;
      // A strobe arriving while busy is dropped and flagged until the next reset.
      if (data_valid && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (data_valid) begin
            r_new_s <= data_in;
            r_old_s <= r_buf[r_wr_ptr];
            r_byp   <= bypass;
          end
        end
        StUpdate: begin
          // Sum always contains old_s, so the subtraction cannot underflow.
          r_sum           <= r_sum + SumW'(r_new_s) - SumW'(r_old_s);
          r_buf[r_wr_ptr] <= r_new_s;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        StOut: begin
          r_data_out       <= r_byp ? r_new_s : r_sum[SumW-1:LOG2N];
          r_data_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign busy           = (r_state != StIdle);
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_adc_moving_avg.sv
// Directed bench for adc_moving_avg: a reference window model pushes expected averages into a
// queue as samples are driven; each output strobe pops and compares.
module tb_adc_moving_avg;

  localparam int DW = 10;
  localparam int L2 = 3;
  localparam int N  = 1 << L2;

  logic          sysclk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          bypass;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          busy;
  logic          overrun;

  adc_moving_avg #(.DATA_W(DW), .LOG2N(L2)) dut (
    .sysclk         (sysclk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .bypass         (bypass),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 sysclk = ~sysclk;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_buf [N];
  int unsigned m_ptr;
  int unsigned m_sum;
  int unsigned exp_q [$];
  int unsigned last_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_buf[i] = 0;
    m_ptr = 0;
    m_sum = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int unsigned v, input bit b);
    m_sum        = m_sum + v - m_buf[m_ptr];
    m_buf[m_ptr] = v;
    m_ptr        = (m_ptr + 1) % N;
    exp_q.push_back(b ? v : m_sum / N);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    data_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one sample; dup holds data_valid into the busy cycle. Bypass and data_in are flipped
  // after acceptance to confirm they were latched.
  task automatic send(input int unsigned v, input bit b, input bit dup, input int gap);
    bit          found;
    int          lat;
    int          extra;
    int unsigned exp_v;
    data_in    = DW'(v);
    bypass     = b;
    data_valid = 1'b1;
    model_push(v, b);
    tick();
    check("busy_after_accept", busy, 1);
    check("no_early_strobe", data_out_valid, 0);
    bypass     = ~b;
    data_in    = DW'(v) ^ {DW{1'b1}};
    data_valid = dup;
    found = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      data_valid = 1'b0;
      if (data_out_valid) begin
        found = 1'b1;
        lat   = c;
        break;
      end
      check("busy_in_out_state", busy, 1);
    end
    check("strobe_seen", found, 1);
    check("latency", lat, 2);
    exp_v    = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    last_exp = exp_v;
    check("data_out", data_out, exp_v);
    check("busy_back_idle", busy, 0);
    tick();
    check("strobe_one_cycle", data_out_valid, 0);
    extra = 0;
    for (int c = 0; c < gap; c++) begin
      tick();
      if (data_out_valid) extra++;
    end
    check("no_extra_strobe", extra, 0);
    check("data_out_held", data_out, last_exp);
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    bypass     = 1'b0;
    do_reset();
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Single sample ramps from an all-zero window.
    send(800, 1'b0, 1'b0, 3);

    // Full window of full-scale samples at slow pacing, then drain with zeros across the wrap.
    do_reset();
    for (int i = 0; i < N; i++) send(1023, 1'b0, 1'b0, 996);
    for (int i = 0; i < N; i++) send(0, 1'b0, 1'b0, 0);
    send(160, 1'b0, 1'b0, 0);

    // Bypass keeps maintaining the window.
    do_reset();
    for (int i = 0; i < N; i++) send(1023, 1'b0, 1'b0, 0);
    send(513, 1'b1, 1'b0, 0);
    send(1023, 1'b0, 1'b0, 0);
    send(7, 1'b1, 1'b0, 0);
    send(250, 1'b0, 1'b0, 0);
    check("overrun_clear", overrun, 0);

    // Overrun: the duplicate strobe is dropped and the flag is sticky.
    do_reset();
    send(640, 1'b0, 1'b1, 4);
    check("overrun_set", overrun, 1);
    for (int i = 0; i < 100; i++) begin
      send($urandom_range(0, 1023), 1'($urandom_range(0, 1)), 1'b0, 0);
      check("overrun_sticky", overrun, 1);
    end

    // Reset while the FSM is in UPDATE.
    data_in    = DW'(123);
    bypass     = 1'b0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    reset      = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    reset = 1'b0;
    model_reset();
    tick();
    check("mid_rst_no_strobe1", data_out_valid, 0);
    tick();
    check("mid_rst_no_strobe2", data_out_valid, 0);
    send(400, 1'b0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
